// File: rtl/axi_req_packer.sv
// ---------------------------------------------------------------------------
// axi_req_packer
//
// Purpose:
//   Collects AXI write-address (AW), write-data (W) and read-address (AR)
//   requests into one-entry holding registers. It joins AW with W into a
//   write request and arbitrates between pending writes and reads. The
//   winning request is packed into a tagged word and placed in an output
//   register that feeds the top (AXI-to-APB) asynchronous FIFO.
//
//   Packed word layout, MSB first:
//       {id, data, strb, prot, addr, write_read}
//   write_read is 1 for a write and 0 for a read. A read carries zero data
//   and strobes.
//
//   Arbitration policy (ARB_MODE):
//     0 : writes win, but after MAX_WR_RUN consecutive write grants with a
//         read waiting, the read is granted.
//     1 : round-robin between write and read when both are pending.
//
// Ports:
//   AXI_clk                  single clock for all logic
//   AXI_rst                  synchronous active-high reset
//   aw_valid/aw_ready        AW handshake
//   aw_addr/aw_prot/aw_id    AW payload
//   w_valid/w_ready          W handshake
//   w_data/w_strb            W payload
//   ar_valid/ar_ready        AR handshake
//   ar_addr/ar_prot/ar_id    AR payload
//   wfull_top                top FIFO full flag
//   conc_data                packed request presented to the top FIFO
//   winc_top                 top FIFO write enable
//   busy                     any holding register or output register valid
// ---------------------------------------------------------------------------
module axi_req_packer #(
    parameter int DATASIZE   = 32,
    parameter int ADDRSIZE   = 32,
    parameter int IDSIZE     = 4,
    parameter int ARB_MODE   = 0,
    parameter int MAX_WR_RUN = 4,
    parameter int PKT_SIZE   = IDSIZE + DATASIZE + DATASIZE/8 + 3 + ADDRSIZE + 1
) (
    input  logic                  AXI_clk,
    input  logic                  AXI_rst,

    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [ADDRSIZE-1:0]   aw_addr,
    input  logic [2:0]            aw_prot,
    input  logic [IDSIZE-1:0]     aw_id,

    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATASIZE-1:0]   w_data,
    input  logic [DATASIZE/8-1:0] w_strb,

    input  logic                  ar_valid,
    output logic                  ar_ready,
    input  logic [ADDRSIZE-1:0]   ar_addr,
    input  logic [2:0]            ar_prot,
    input  logic [IDSIZE-1:0]     ar_id,

    input  logic                  wfull_top,
    output logic [PKT_SIZE-1:0]   conc_data,
    output logic                  winc_top,
    output logic                  busy
);

    localparam int STRBSIZE = DATASIZE / 8;
    localparam logic [3:0] RUN_LIMIT = 4'(MAX_WR_RUN);

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    // AW holding register
    logic                aw_held;
    logic [ADDRSIZE-1:0] aw_addr_q;
    logic [2:0]          aw_prot_q;
    logic [IDSIZE-1:0]   aw_id_q;

    // W holding register
    logic                w_held;
    logic [DATASIZE-1:0] w_data_q;
    logic [STRBSIZE-1:0] w_strb_q;

    // AR holding register
    logic                ar_held;
    logic [ADDRSIZE-1:0] ar_addr_q;
    logic [2:0]          ar_prot_q;
    logic [IDSIZE-1:0]   ar_id_q;

    // Output register and arbitration state
    logic                out_valid;
    logic [PKT_SIZE-1:0] out_data;
    logic [3:0]          wr_run;
    grant_t              last_grant;

    // Combinational control
    logic                wr_pend;
    logic                rd_pend;
    logic                out_free;
    logic                arb_en;
    logic                pick_wr;
    logic                grant_wr;
    logic                grant_rd;
    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic [PKT_SIZE-1:0] wr_pkt;
    logic [PKT_SIZE-1:0] rd_pkt;

    assign wr_pend  = aw_held & w_held;
    assign rd_pend  = ar_held;

    // The output register can accept a new packet when it is empty or when
    // its current packet leaves for the FIFO this very cycle.
    assign out_free = !out_valid | !wfull_top;
    assign arb_en   = out_free & (wr_pend | rd_pend);

    // Arbitration. pick_wr says which side would win if a grant happens;
    // the grants themselves are qualified by arb_en.
    always_comb begin
        pick_wr = 1'b0;
        if (ARB_MODE == 1) begin
            if (wr_pend && rd_pend) begin
                pick_wr = (last_grant == GRANT_READ);
            end else begin
                pick_wr = wr_pend;
            end
        end else begin
            pick_wr = wr_pend && !(rd_pend && (wr_run == RUN_LIMIT));
        end
    end

    assign grant_wr = arb_en & pick_wr;
    assign grant_rd = arb_en & rd_pend & !pick_wr;

    // A holding register can take new data when empty or when its content is
    // consumed by a grant in the same cycle; this keeps one request per cycle.
    assign aw_ready = !aw_held | grant_wr;
    assign w_ready  = !w_held  | grant_wr;
    assign ar_ready = !ar_held | grant_rd;

    assign aw_hs = aw_valid & aw_ready;
    assign w_hs  = w_valid  & w_ready;
    assign ar_hs = ar_valid & ar_ready;

    // Packed words for both request kinds.
    assign wr_pkt = {aw_id_q, w_data_q, w_strb_q, aw_prot_q, aw_addr_q, 1'b1};
    assign rd_pkt = {ar_id_q, {DATASIZE{1'b0}}, {STRBSIZE{1'b0}},
                     ar_prot_q, ar_addr_q, 1'b0};

    // AW holding register: captures on handshake, empties on a write grant.
    always_ff @(posedge AXI_clk) begin
        if (AXI_rst) begin
            aw_held   <= 1'b0;
            aw_addr_q <= '0;
            aw_prot_q <= '0;
            aw_id_q   <= '0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= aw_addr;
                aw_prot_q <= aw_prot;
                aw_id_q   <= aw_id;
            end else if (grant_wr) begin
                aw_held   <= 1'b0;
            end
        end
    end

    // W holding register: same life cycle as AW.
    always_ff @(posedge AXI_clk) begin
        if (AXI_rst) begin
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= w_data;
                w_strb_q <= w_strb;
            end else if (grant_wr) begin
                w_held   <= 1'b0;
            end
        end
    end

    // AR holding register: captures on handshake, empties on a read grant.
    always_ff @(posedge AXI_clk) begin
        if (AXI_rst) begin
            ar_held   <= 1'b0;
            ar_addr_q <= '0;
            ar_prot_q <= '0;
            ar_id_q   <= '0;
        end else begin
            if (ar_hs) begin
                ar_held   <= 1'b1;
                ar_addr_q <= ar_addr;
                ar_prot_q <= ar_prot;
                ar_id_q   <= ar_id;
            end else if (grant_rd) begin
                ar_held   <= 1'b0;
            end
        end
    end

    // Output register. A grant reloads it; otherwise it empties once the
    // FIFO takes the packet. conc_data only changes on a load.
    always_ff @(posedge AXI_clk) begin
        if (AXI_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (grant_wr) begin
                out_valid <= 1'b1;
                out_data  <= wr_pkt;
            end else if (grant_rd) begin
                out_valid <= 1'b1;
                out_data  <= rd_pkt;
            end else if (winc_top) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Anti-starvation run counter: counts write grants that overtook a
    // waiting read and saturates at the limit, which then forces a read.
    always_ff @(posedge AXI_clk) begin
        if (AXI_rst) begin
            wr_run <= 4'd0;
        end else begin
            if (grant_rd || !rd_pend) begin
                wr_run <= 4'd0;
            end else if (grant_wr && (wr_run != RUN_LIMIT)) begin
                wr_run <= wr_run + 4'd1;
            end
        end
    end

    // Round-robin memory: remembers which side got the most recent grant.
    always_ff @(posedge AXI_clk) begin
        if (AXI_rst) begin
            last_grant <= GRANT_READ;
        end else begin
            if (grant_wr) begin
                last_grant <= GRANT_WRITE;
            end else if (grant_rd) begin
                last_grant <= GRANT_READ;
            end
        end
    end

    assign winc_top  = out_valid & !wfull_top;
    assign conc_data = out_data;
    assign busy      = aw_held | w_held | ar_held | out_valid;

endmodule

// File: doc/axi_req_packer.md
# axi_req_packer

Registered, parametrised successor to the AXI-side request concatenator of the AXI-to-APB bridge. It accepts independent AXI write-address (AW), write-data (W) and read-address (AR) channels. It joins AW with W, arbitrates between write and read requests with a selectable policy that prevents read starvation, and packs the winning request into a tagged word. An output register then writes that word into the top (AXI-to-APB) asynchronous FIFO.

## Interface
Parameters:
- DATASIZE, 32: AXI/APB data width; multiple of 8.
- ADDRSIZE, 32: address width.
- IDSIZE, 4: transaction ID width, carried to the APB side for response routing.
- ARB_MODE, 0: 0 = write priority with read anti-starvation; 1 = round-robin.
- MAX_WR_RUN, 4: ARB_MODE 0 only. Maximum number of consecutive write grants while a read is waiting. Range 1..15.
- PKT_SIZE, IDSIZE+DATASIZE+DATASIZE/8+3+ADDRSIZE+1: packed word width (derived; do not override).

Ports:
- AXI_clk, in, 1: single clock for all logic.
- AXI_rst, in, 1: reset; synchronous, active-high.
- aw_valid / aw_ready, in / out, 1 / 1: AW handshake.
- aw_addr, in, ADDRSIZE: write address.
- aw_prot, in, 3: write protection bits.
- aw_id, in, IDSIZE: write ID.
- w_valid / w_ready, in / out, 1 / 1: W handshake.
- w_data, in, DATASIZE: write data.
- w_strb, in, DATASIZE/8: write strobes.
- ar_valid / ar_ready, in / out, 1 / 1: AR handshake.
- ar_addr, in, ADDRSIZE: read address.
- ar_prot, in, 3: read protection bits.
- ar_id, in, IDSIZE: read ID.
- wfull_top, in, 1: top FIFO full flag.
- conc_data, out, PKT_SIZE: packed request, {id, data, strb, prot, addr, write_read}, MSB first.
- winc_top, out, 1: top FIFO write enable.
- busy, out, 1: any holding register or the output register is valid.

## Operation
- Three one-entry holding registers: AW, W, AR. Each has a valid flag and captures its payload on its valid&ready handshake.
- Ready rule for each channel: ready = !held | consumed_this_cycle. This gives full throughput, and ready has a combinational path from wfull_top.
- AW and W may arrive in either order or in the same cycle. A write is pending only when both AW and W are held. A lone AW or lone W waits indefinitely.
- The output register is free when !out_valid | (out_valid & !wfull_top).
- Arbitration is evaluated every cycle in which the output register is free and at least one request is pending. Exactly one request is granted. A grant consumes its holding register(s) and loads the output register.
- ARB_MODE 0:
  - Write wins, unless a read is pending and wr_run == MAX_WR_RUN; then the read wins.
  - wr_run (4-bit) increments on a write grant while a read is pending, and saturates at MAX_WR_RUN.
  - wr_run clears on a read grant and whenever no read is pending.
- ARB_MODE 1:
  - When both are pending, the grant goes to the opposite of the 1-bit last_grant.
  - last_grant updates on every grant. It resets to "read", so the first contested grant goes to write.
- Packing:
  - write_read = 1 for a write, 0 for a read.
  - For a read: data and strb fields are 0. id, prot and addr come from AR.
  - For a write: all fields come from the AW and W holding registers.
- winc_top = out_valid & !wfull_top. When winc_top is high, out_valid clears that cycle unless a new grant reloads the register.
- When wfull_top is high, conc_data and out_valid hold stable. No new grant occurs, and readies fall for held channels.

## Timing
- Reset values (AXI_rst sampled high at a clock edge): all valid flags 0, wr_run 0, last_grant = read.
  - Outputs: aw_ready, w_ready and ar_ready = 1 (with wfull_top low or high, since nothing is held); winc_top 0; busy 0; conc_data 0.
- Reset asserted mid-operation discards held and output requests without writing them to the FIFO.
- Latency:
  - Handshake at edge N; holding register valid in cycle N+1; grant loads the output register at edge N+1.
  - winc_top is high in cycle N+2 if wfull_top is low.
  - A write completes when the later of its AW and W handshakes occurs, which sets N.
- Throughput: one packet per cycle sustained while wfull_top stays low.
- conc_data changes only at an edge where the output register loads.
- Simultaneous AW, W and AR in the same cycle are all accepted. Arbitration then orders the write and read packets.

## Test plan
- Reset, then a single write: aw_addr=0x1000, aw_id=3, prot=2, w_data=0xDEADBEEF, strb=0xF in the same cycle.
  - Expect winc_top high exactly 2 cycles later, write_read=1, and all fields matching.
- W given 3 cycles before AW (addr 0x20): w_ready then stays high only until W is held.
  - Expect one packet 2 cycles after the AW handshake, with no packet before that.
- ARB_MODE 0, MAX_WR_RUN=4: writes back-to-back, one read held continuously.
  - Expect packet sequence W,W,W,W,R,W..., wr_run cleared after the read.
- ARB_MODE 1: writes and reads both continuously pending.
  - Expect packets alternating W,R,W,R, starting with W after reset.
- Hold wfull_top=1 for 5 cycles with a packet in the output register.
  - Expect winc_top 0, conc_data stable and readies low for held channels.
  - On release, the packet is written in the first cycle and the next packet follows in the following cycle.
- Assert AXI_rst for 1 cycle while AW, AR and the output register are valid.
  - Expect winc_top and busy 0 in the next cycle and no stale packet afterwards.
